// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared TD4 constants and loader state encoding
// Contents: DATA_W / ADDR_W / ROM_DEPTH constants and the loader FSM state type.
package td4_pkg;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CHK  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - program loader stream, fetch and status bundle
// master: drives LOAD_REQ, DIN, DIN_VALID, A; observes DIN_READY, Q, CPU_RESET, DONE, ERR.
// slave : the loader side, directions reversed.
interface prog_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              LOAD_REQ;
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Q;
  logic              CPU_RESET;
  logic              DONE;
  logic              ERR;

  modport master (
    output LOAD_REQ, DIN, DIN_VALID, A,
    input  DIN_READY, Q, CPU_RESET, DONE, ERR
  );

  modport slave (
    input  LOAD_REQ, DIN, DIN_VALID, A,
    output DIN_READY, Q, CPU_RESET, DONE, ERR
  );
endinterface

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 16 x 8 program register file, sync write, async read
// Ports: CLK, RESET (async, clears all words), we/waddr/wdata write port,
//        raddr -> rdata combinational read (no write bypass).
module prog_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - TD4 program loader: byte stream -> program memory, checksum gate
// Ports: CLK, RESET (async active-high), bus (slave): LOAD_REQ, DIN/DIN_VALID/DIN_READY
//        stream, A -> Q fetch read, CPU_RESET/DONE/ERR status.
module prog_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  prog_loader_if.slave  bus
);
  import td4_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d, sum_next;
  logic              err_q, err_d;
  logic              in_stream, handshake, mem_we;

  // Status outputs decode purely from registers; no input reaches them combinationally.
  assign in_stream     = (state_q == ST_LOAD) || (state_q == ST_CHK);
  assign bus.DIN_READY = in_stream;
  assign bus.CPU_RESET = (state_q != ST_RUN);
  assign bus.DONE      = (state_q == ST_RUN);
  assign bus.ERR       = err_q;

  assign handshake = bus.DIN_VALID & in_stream;
  assign sum_next  = sum_q + bus.DIN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.LOAD_REQ) state_d = ST_LOAD;
      ST_LOAD: if (handshake && (cnt_q == '1)) state_d = ST_CHK;
      ST_CHK:  if (handshake) state_d = (sum_next == '0) ? ST_RUN : ST_IDLE;
      ST_RUN:  if (bus.LOAD_REQ) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    err_d  = err_q;
    mem_we = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (bus.LOAD_REQ) begin
          cnt_d = '0;
          sum_d = '0;
          err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          mem_we = 1'b1;
          sum_d  = sum_next;
          cnt_d  = cnt_q + 1'b1;  // wraps to 0 on the 16th byte
        end
      end
      ST_CHK: begin
        // Checksum byte only closes the sum; it never lands in memory.
        if (handshake && (sum_next != '0)) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  prog_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (mem_we),
    .waddr (cnt_q),
    .wdata (bus.DIN),
    .raddr (bus.A),
    .rdata (bus.Q)
  );
endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory writer for the TD4 core: accepts a 16-byte program plus one checksum byte over a valid/ready byte stream and stores it in a 16 x 8 register file. It exposes the same combinational A -> Q read contract as the switch ROM, so it drops in where SW_ROM sits in front of the instruction fetch. It holds the core in reset until a load completes with a good checksum.

## Interface

Parameters:
- DATA_W, 8, instruction byte width.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- RESET, input, 1, asynchronous, active-high.
- LOAD_REQ, input, 1, start (or restart) a program load; sampled on CLK.
- DIN, input, DATA_W, stream byte.
- DIN_VALID, input, 1, DIN holds a valid byte.
- DIN_READY, output, 1, loader accepts a byte this cycle.
- A, input, ADDR_W, fetch address from the program counter.
- Q, output, DATA_W, combinational read data, mem[A].
- CPU_RESET, output, 1, hold core in reset; high whenever a valid program is not loaded.
- DONE, output, 1, valid program loaded, core running.
- ERR, output, 1, last load failed its checksum; sticky until next LOAD_REQ or RESET.

## Operation

- States: IDLE, LOAD, CHK, RUN (state register only; all outputs except Q decode from registers).
- RESET: state=IDLE, mem[0..15]=0x00, cnt=0, sum=0x00; CPU_RESET=1, DIN_READY=0, DONE=0, ERR=0, Q=0x00.
- IDLE: CPU_RESET=1. LOAD_REQ=1 -> LOAD; clear cnt, sum, ERR.
- LOAD: DIN_READY=1. On handshake (DIN_VALID & DIN_READY): mem[cnt]<=DIN, sum<=sum+DIN (mod 256), cnt<=cnt+1. Handshake at cnt=15 -> CHK (cnt wraps to 0, no further writes).
- CHK: DIN_READY=1. On handshake: if (sum+DIN) mod 256 == 0x00 -> RUN; else ERR<=1 -> IDLE. Checksum byte is never written to memory.
- RUN: CPU_RESET=0, DONE=1, DIN_READY=0. LOAD_REQ=1 -> LOAD (reload; clears cnt, sum, DONE).
- LOAD_REQ while in LOAD or CHK: ignored; the load in progress continues.
- DIN_VALID low: no state change; cnt and sum hold indefinitely (no timeout).
- DIN_VALID outside LOAD/CHK: ignored; DIN_READY low.
- Failed load: memory keeps partially written contents; CPU_RESET stays 1.
- Q=mem[A] in every state, including during load.

## Timing

- LOAD_REQ sampled at edge N -> DIN_READY=1 and CPU_RESET=1 from edge N (after N's update).
- Minimum load: 17 handshake cycles; good checksum at edge M -> CPU_RESET=0, DONE=1 after edge M.
- Write visibility: write at edge N; Q for that address shows the new byte after edge N. In the cycle of the write Q shows the old value (no bypass).
- Reload from RUN: CPU_RESET rises and DONE falls after the edge sampling LOAD_REQ.
- RESET asserted mid-load: immediate return to reset values, including memory clear; no partial-state retention.
- No combinational path from DIN, DIN_VALID or LOAD_REQ to any output; A -> Q is the only combinational path.

## Structure

- Shared package td4_pkg: state encoding (IDLE, LOAD, CHK, RUN), DATA_W=8, ADDR_W=4, ROM_DEPTH=16.
- Sub-module prog_mem: 16 x 8 register file with one synchronous write port (we, waddr, wdata), asynchronous clear on RESET, and a combinational read port (A -> Q). prog_loader holds the FSM, counter, and checksum accumulator.

## Test plan

- Reset: RESET=1 -> CPU_RESET=1, DONE=0, ERR=0, DIN_READY=0; sweep A=0..15 -> Q=0x00 for every address.
- Good load: LOAD_REQ, stream 0x00..0x0F, then checksum 0x88 (sum 0x78) -> DONE=1, CPU_RESET=0; sweep A=0..15 -> Q=A.
- Bad checksum: same stream, checksum 0x87 -> ERR=1, state IDLE, CPU_RESET=1; Q still reads 0x00..0x0F.
- Back-pressure: DIN_VALID toggled 1-0-1 per cycle during the load -> 17 accepted bytes, correct memory contents, DONE=1 only after the 17th handshake; LOAD_REQ pulsed mid-load is ignored.
- Reload and reset mid-load: from RUN, LOAD_REQ -> CPU_RESET=1 the next cycle; write 0xA5 to mem[0] (Q(A=0) changes only after the edge); assert RESET after 5 bytes -> all outputs return to reset values, Q=0x00.
